// File: rtl/fir_interp2.sv
// Interpolate-by-2 transmit FIR: one sample in, two out, 4-tap symmetric polyphase {b0,b1,b1,b0}.
// Optional macro FIR_INTERP_SATURATE_EN makes every term and accumulation saturate instead of wrapping.
`timescale 1ns/1ps
module fir_interp2 #(
  parameter int N     = 16,
  parameter int SHIFT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] b1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y
);

  typedef enum logic [2:0] {
    IDLE, MAC_E0, MAC_E1, OUT_E, MAC_O0, MAC_O1, OUT_O
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] xc_q, xc_d, x1_q, x1_d;
  logic [N-1:0] c0_q, c0_d, c1_q, c1_d;
  logic [N-1:0] acc_q, acc_d, y_q, y_d;

  logic [N-1:0] mul_s, mul_c, term, mac_sum;

  // Shared multiplier: the first MAC cycle of each phase uses the newest sample,
  // the second uses the history sample; coefficients swap between phases.
  always_comb begin
    mul_s = ((state_q == MAC_E0) || (state_q == MAC_O0)) ? xc_q : x1_q;
    mul_c = ((state_q == MAC_E0) || (state_q == MAC_O1)) ? c0_q : c1_q;
  end

`ifdef FIR_INTERP_SATURATE_EN
  logic [2*N-1:0] shifted;
  logic [N:0]     sum_w;
  always_comb begin
    shifted = ((2*N)'(mul_s) * (2*N)'(mul_c)) >> SHIFT;
    term    = (|shifted[2*N-1:N]) ? {N{1'b1}} : shifted[N-1:0];
    sum_w   = {1'b0, acc_q} + {1'b0, term};
    mac_sum = sum_w[N] ? {N{1'b1}} : sum_w[N-1:0];
  end
`else
  always_comb begin
    term    = N'(((2*N)'(mul_s) * (2*N)'(mul_c)) >> SHIFT);
    mac_sum = acc_q + term;
  end
`endif

  always_comb begin
    state_d = state_q;
    xc_d    = xc_q;
    x1_d    = x1_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (in_valid) begin
        xc_d    = X;
        c0_d    = b0;
        c1_d    = b1;
        state_d = MAC_E0;
      end
      MAC_E0: begin acc_d = term;  state_d = MAC_E1; end
      MAC_E1: begin y_d = mac_sum; state_d = OUT_E;  end
      OUT_E:  if (out_ready) state_d = MAC_O0;
      MAC_O0: begin acc_d = term;  state_d = MAC_O1; end
      MAC_O1: begin y_d = mac_sum; state_d = OUT_O;  end
      OUT_O:  if (out_ready) begin
        x1_d    = xc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over any handshake in flight; Y deliberately keeps its last value.
    if (clr) begin
      state_d = IDLE;
      xc_d    = xc_q;
      c0_d    = c0_q;
      c1_d    = c1_q;
      x1_d    = '0;
      acc_d   = '0;
      y_d     = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xc_q    <= '0;
      x1_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      xc_q    <= xc_d;
      x1_q    <= x1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT_E) || (state_q == OUT_O);
  assign Y         = y_q;

endmodule
